// File: rtl/sm_fp_conv_seq.sv
// ---------------------------------------------------------------------------
// sm_fp_conv_seq
//
// Sequential converter between a sign-magnitude integer and a
// sign/exponent/fraction float whose value is (-1)^s * 0.f * 2^e.
// The float has no hidden bit. Normalisation (int->fp) and denormalisation
// (fp->int) use a one-bit-per-cycle shifter.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer offers an operand with in_valid and it is taken
// when in_ready is high. The result is offered with out_valid and released
// when out_ready is high. The converter holds only one operation at a time.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operand valid
//   in_ready   converter idle and able to accept
//   mode       0 = int->fp, 1 = fp->int (sampled on accept)
//   in_int     sign-magnitude integer operand {s, mag[IW-2:0]}
//   in_fp      float operand {s, e[EW-1:0], f[FW-1:0]}
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer takes the result
//   out_int    sign-magnitude result (fp->int only)
//   out_fp     float result (int->fp only)
//   out_of     fp->int exponent too large, magnitude saturated
//   out_uf     fp->int exponent below 1, magnitude zero
//   dbg_state  current FSM state, for observation
// ---------------------------------------------------------------------------
module sm_fp_conv_seq #(
    parameter int IW = 8,
    parameter int EW = 4,
    parameter int FW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [IW-1:0]    in_int,
    input  logic [EW+FW:0]   in_fp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_int,
    output logic [EW+FW:0]   out_fp,
    output logic             out_of,
    output logic             out_uf,
    output logic [1:0]       dbg_state
);

    // The fraction must hold a whole integer magnitude, and the exponent
    // must be able to count down from FW.
    if (FW < IW - 1 || (2 ** EW) - 1 < FW) begin : g_bad_params
        $error("sm_fp_conv_seq: illegal parameters, need FW >= IW-1 and 2^EW-1 >= FW");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [EW-1:0] E_MAX = EW'(IW - 1);  // largest exponent that fits
    localparam logic [EW-1:0] E_FW  = EW'(FW);

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic            sign_q, sign_d;
    logic [FW-1:0]   work_q, work_d;
    // int->fp: running exponent. fp->int: shifts still to do.
    logic [EW-1:0]   cnt_q, cnt_d;
    logic            of_pend_q, of_pend_d;
    logic            uf_pend_q, uf_pend_d;
    logic [IW-1:0]   out_int_q, out_int_d;
    logic [EW+FW:0]  out_fp_q, out_fp_d;
    logic            out_of_q, out_of_d;
    logic            out_uf_q, out_uf_d;

    logic [EW-1:0]   in_e;
    logic [FW-1:0]   in_f;
    logic            shift_done;
    logic            work_zero;

    assign in_e      = in_fp[EW+FW-1:FW];
    assign in_f      = in_fp[FW-1:0];
    assign work_zero = (work_q == '0);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sign_d     = sign_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        of_pend_d  = of_pend_q;
        uf_pend_d  = uf_pend_q;
        out_int_d  = out_int_q;
        out_fp_d   = out_fp_q;
        out_of_d   = out_of_q;
        out_uf_d   = out_uf_q;
        shift_done = 1'b0;

        // int->fp stops on a zero magnitude or once the MSB is set.
        // fp->int stops when the shift budget set at load runs out.
        if (!mode_q) begin
            shift_done = work_zero || work_q[FW-1];
        end else begin
            shift_done = (cnt_q == '0);
        end

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_SHIFT;
                    mode_d    = mode;
                    of_pend_d = 1'b0;
                    uf_pend_d = 1'b0;
                    if (!mode) begin
                        sign_d             = in_int[IW-1];
                        work_d             = '0;
                        work_d[IW-2:0]     = in_int[IW-2:0];
                        cnt_d              = E_FW;
                    end else begin
                        sign_d = in_fp[EW+FW];
                        // Special cases load a finished result with a zero
                        // shift budget, so they leave SHIFT on the next edge.
                        if (in_f == '0) begin
                            work_d = '0;
                            cnt_d  = '0;
                        end else if (in_e > E_MAX) begin
                            work_d    = '1;
                            cnt_d     = '0;
                            of_pend_d = 1'b1;
                        end else if (in_e == '0) begin
                            work_d    = '0;
                            cnt_d     = '0;
                            uf_pend_d = 1'b1;
                        end else begin
                            work_d = in_f;
                            cnt_d  = E_FW - in_e;
                        end
                    end
                end
            end

            S_SHIFT: begin
                if (shift_done) begin
                    state_d = S_DONE;
                    if (!mode_q) begin
                        // Zero keeps its sign but reports e=0, not e=FW.
                        out_fp_d = {sign_q, (work_zero ? {EW{1'b0}} : cnt_q), work_q};
                    end else begin
                        out_int_d = {sign_q, work_q[IW-2:0]};
                        out_of_d  = of_pend_q;
                        out_uf_d  = uf_pend_q;
                    end
                end else begin
                    cnt_d = cnt_q - EW'(1);
                    if (!mode_q) begin
                        work_d = work_q << 1;
                    end else begin
                        work_d = work_q >> 1;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d   = S_IDLE;
                    out_int_d = '0;
                    out_fp_d  = '0;
                    out_of_d  = 1'b0;
                    out_uf_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            sign_q    <= 1'b0;
            work_q    <= '0;
            cnt_q     <= '0;
            of_pend_q <= 1'b0;
            uf_pend_q <= 1'b0;
            out_int_q <= '0;
            out_fp_q  <= '0;
            out_of_q  <= 1'b0;
            out_uf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            sign_q    <= sign_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            of_pend_q <= of_pend_d;
            uf_pend_q <= uf_pend_d;
            out_int_q <= out_int_d;
            out_fp_q  <= out_fp_d;
            out_of_q  <= out_of_d;
            out_uf_q  <= out_uf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_int   = out_int_q;
    assign out_fp    = out_fp_q;
    assign out_of    = out_of_q;
    assign out_uf    = out_uf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sm_fp_conv_seq.sv
// ---------------------------------------------------------------------------
// tb_sm_fp_conv_seq
//
// Directed and random bench for sm_fp_conv_seq with IW=8, EW=4, FW=8.
// Expected results for random operands come from an arithmetic model of the
// conversion rules, which uses bit length, shifts and range tests on integers.
// Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_sm_fp_conv_seq;
    localparam int IW = 8;
    localparam int EW = 4;
    localparam int FW = 8;
    localparam int PW = 1 + EW + FW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          mode;
    logic [IW-1:0] in_int;
    logic [PW-1:0] in_fp;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_int;
    logic [PW-1:0] out_fp;
    logic          out_of;
    logic          out_uf;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    sm_fp_conv_seq #(.IW(IW), .EW(EW), .FW(FW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in_int    (in_int),
        .in_fp     (in_fp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_fp    (out_fp),
        .out_of    (out_of),
        .out_uf    (out_uf),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of the conversion rules, including the number of shift steps k.
    function automatic void model(input logic m, input logic [IW-1:0] ii, input logic [PW-1:0] fi,
                                  output logic [IW-1:0] e_int, output logic [PW-1:0] e_fp,
                                  output logic e_of, output logic e_uf, output int k);
        int s, mag, bl, e, f;
        e_int = '0;
        e_fp  = '0;
        e_of  = 1'b0;
        e_uf  = 1'b0;
        k     = 0;
        if (!m) begin
            s   = int'(ii[IW-1]);
            mag = int'(ii[IW-2:0]);
            bl  = 0;
            while ((1 << bl) <= mag) bl++;
            if (mag == 0) begin
                e_fp = PW'(s << (EW + FW));
            end else begin
                k    = FW - bl;
                e_fp = PW'((s << (EW + FW)) | (bl << FW) | ((mag << k) & ((1 << FW) - 1)));
            end
        end else begin
            s = int'(fi[PW-1]);
            e = int'(fi[PW-2:FW]);
            f = int'(fi[FW-1:0]);
            if (f == 0) begin
                mag = 0;
            end else if (e > IW - 1) begin
                mag  = (1 << (IW - 1)) - 1;
                e_of = 1'b1;
            end else if (e < 1) begin
                mag  = 0;
                e_uf = 1'b1;
            end else begin
                k   = FW - e;
                mag = f >> k;
            end
            e_int = IW'((s << (IW - 1)) | mag);
        end
    endfunction

    // Starts #1 after a rising edge with the DUT idle, and returns at the same
    // phase with the DUT idle again.
    task automatic run_op(input string tag, input logic m, input logic [IW-1:0] ii,
                          input logic [PW-1:0] fi, input logic [IW-1:0] e_int,
                          input logic [PW-1:0] e_fp, input logic e_of, input logic e_uf,
                          input int e_lat, input int hold);
        int n;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        mode      = m;
        in_int    = ii;
        in_fp     = fi;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        // Operand changes after accept must not matter.
        in_valid = 1'b0;
        mode     = 1'($urandom);
        in_int   = IW'($urandom);
        in_fp    = PW'($urandom);
        n = 0;
        while (n < FW + 6) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
            check({tag, " busy in_ready"}, 32'(in_ready), 32'd0);
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(e_lat));
        check({tag, " out_int"}, 32'(out_int), 32'(e_int));
        check({tag, " out_fp"}, 32'(out_fp), 32'(e_fp));
        check({tag, " out_of"}, 32'(out_of), 32'(e_of));
        check({tag, " out_uf"}, 32'(out_uf), 32'(e_uf));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            mode     = 1'($urandom);
            in_int   = IW'($urandom);
            in_fp    = PW'($urandom);
            @(posedge clk); #1;
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " hold out_int"}, 32'(out_int), 32'(e_int));
            check({tag, " hold out_fp"}, 32'(out_fp), 32'(e_fp));
            check({tag, " hold flags"}, 32'({out_of, out_uf}), 32'({e_of, e_uf}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " release out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " release in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " release outputs"}, 32'({out_int, out_fp, out_of, out_uf}), 32'd0);
    endtask

    initial begin
        logic          rm;
        logic [IW-1:0] ri, x_int;
        logic [PW-1:0] rf, x_fp;
        logic          x_of, x_uf;
        int            x_k;

        reset     = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        in_int    = '0;
        in_fp     = '0;
        out_ready = 1'b0;
        #2;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset outputs", 32'({out_int, out_fp, out_of, out_uf}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-derived results.
        run_op("i2f pos",   1'b0, 8'h05, '0,      8'h00, 13'h03A0, 1'b0, 1'b0, 6, 0);
        run_op("i2f negz",  1'b0, 8'h80, '0,      8'h00, 13'h1000, 1'b0, 1'b0, 1, 0);
        run_op("i2f max",   1'b0, 8'hFF, '0,      8'h00, 13'h17FE, 1'b0, 1'b0, 2, 0);
        run_op("f2i norm",  1'b1, 8'h00, 13'h13A0, 8'h85, 13'h0000, 1'b0, 1'b0, 6, 0);
        run_op("f2i of",    1'b1, 8'h00, 13'h0980, 8'h7F, 13'h0000, 1'b1, 1'b0, 1, 0);
        run_op("f2i uf",    1'b1, 8'h00, 13'h0080, 8'h00, 13'h0000, 1'b0, 1'b1, 1, 0);
        run_op("f2i zero",  1'b1, 8'h00, 13'h0500, 8'h00, 13'h0000, 1'b0, 1'b0, 1, 0);
        run_op("backpress", 1'b0, 8'h05, '0,      8'h00, 13'h03A0, 1'b0, 1'b0, 6, 4);

        // Reset in the middle of a long normalisation (in_int=1 needs 7 shifts).
        in_valid  = 1'b1;
        mode      = 1'b0;
        in_int    = 8'h01;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset outputs", 32'({out_int, out_fp, out_of, out_uf}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("after reset in_ready", 32'(in_ready), 32'd1);
        run_op("post reset", 1'b1, 8'h00, 13'h1780, 8'hC0, 13'h0000, 1'b0, 1'b0, 2, 0);

        // Random operands against the model.
        for (int t = 0; t < 60; t++) begin
            rm = 1'($urandom);
            ri = IW'($urandom);
            rf = PW'($urandom);
            model(rm, ri, rf, x_int, x_fp, x_of, x_uf, x_k);
            run_op($sformatf("rnd%0d", t), rm, ri, rf, x_int, x_fp, x_of, x_uf,
                   x_k + 1, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Whole-run time limit.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sm_fp_conv_seq.md
Name: sm_fp_conv_seq

Overview:
- Sequential, parametrised bidirectional converter between sign-magnitude integers and a sign/exponent/fraction floating-point format. The value represented is (-1)^s × 0.f × 2^e, with no hidden bit.
- Normalisation and denormalisation run on a one-bit-per-cycle iterative shifter, so area stays small.
- It sits between a producer and a consumer, with valid/ready handshakes on both sides.
- It is the multi-cycle, width-generic successor to the fixed 8-bit/13-bit combinational converters.

Parameters:
- IW, 8: integer width. Bit IW-1 is the sign; IW-1 magnitude bits.
- EW, 4: exponent width, unsigned.
- FW, 8: fraction width.
- Legality (elaboration check): FW >= IW-1 and 2^EW-1 >= FW.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept; equals (state==IDLE).
- mode  in  1  0 = int->fp, 1 = fp->int; sampled only on accept.
- in_int  in  IW  sign-magnitude integer operand (mode 0).
- in_fp  in  1+EW+FW  {s, e, f} operand (mode 1).
- out_valid  out  1  result valid; equals (state==DONE).
- out_ready  in  1  consumer accepts the result.
- out_int  out  IW  sign-magnitude result (mode 1).
- out_fp  out  1+EW+FW  {s, e, f} result (mode 0).
- out_of  out  1  overflow flag (mode 1).
- out_uf  out  1  underflow flag (mode 1).

Behaviour:
- Reset asserted, at any time including mid-operation:
  - state goes to IDLE and any in-flight operation is discarded.
  - All outputs are 0 except in_ready, which is 1.
- Accept occurs on a clock edge where state==IDLE and in_valid is high.
  - The edge registers mode, sign, and the work register, then state goes to SHIFT.
  - mode and operand changes after accept are ignored.
- Int->fp load:
  - sign = in_int[IW-1].
  - work = magnitude zero-extended into FW bits, LSB-aligned.
  - exp counter = FW.
- Int->fp in SHIFT:
  - If magnitude is 0, finish with e=0, f=0 and sign passed through (-0 stays signed).
  - Otherwise, while work[FW-1]==0: shift work left 1 and decrement the counter, one step per cycle.
  - Result: e = bitlength(magnitude), f = work.
  - k = FW - bitlength.
- Fp->int classification on load (priority order):
  1. f==0 -> result 0, no flags.
  2. e > IW-1 -> out_of=1, magnitude saturates to all ones.
  3. e < 1 -> out_uf=1, magnitude 0.
  4. Otherwise normal.
- Fp->int normal case:
  - work = f, shifted right 1 per cycle, FW-e times.
  - Result magnitude = work[IW-2:0]; sign passes through in all cases.
  - For the three special cases, k=0.
- Latency:
  - out_valid asserts exactly k+1 rising edges after the accept edge.
  - k = number of one-bit shifts, 0..FW.
- State machine, with states IDLE, SHIFT, DONE:
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT while shifts remain.
  - SHIFT -> DONE on the edge at which the termination condition holds.
  - DONE -> IDLE on the edge with out_ready=1.
- Output rules:
  - Outputs are registered.
  - In DONE, all outputs hold stable until the handshake completes.
  - out_fp is 0 in mode 1 and out_int/flags are 0 in mode 0.
  - Outputs are cleared to 0 when leaving DONE.
- in_ready is 0 in SHIFT and DONE; there is no overlap of operations.
- out_ready high outside DONE has no effect.

Test Plan:
All scenarios use IW=8, EW=4, FW=8.
- Int->fp, positive: mode=0, in_int=8'h05 -> out_fp=13'h03A0 (s=0, e=3, f=8'hA0); out_valid 6 edges after accept.
- Int->fp, negative zero: mode=0, in_int=8'h80 -> out_fp=13'h1000, out_of=0, out_uf=0; out_valid 1 edge after accept.
- Int->fp, maximum: mode=0, in_int=8'hFF -> out_fp=13'h17FE (s=1, e=7, f=8'hFE); k=1.
- Fp->int, normal: mode=1, in_fp=13'h13A0 -> out_int=8'h85; out_valid 6 edges after accept.
- Fp->int, special cases:
  - in_fp=13'h0980 -> out_of=1, out_int=8'h7F; latency 1.
  - in_fp=13'h0080 -> out_uf=1, out_int=8'h00.
  - in_fp=13'h0500 -> out_int=8'h00, no flags.
- Backpressure and reset:
  - Hold out_ready=0 for 4 cycles in DONE -> outputs stable, in_ready=0, and a concurrent in_valid is not accepted.
  - Assert reset mid-SHIFT -> immediate IDLE, all outputs 0, in_ready=1; the next operation converts correctly.
